// File: rtl/err_inj_pkg.sv
// rtl/err_inj_pkg.sv - shared types and helpers for the channel error injector
package err_inj_pkg;

    typedef enum logic [1:0] {
        MODE_OFF        = 2'd0,
        MODE_PERIODIC   = 2'd1,
        MODE_RANDOM     = 2'd2,
        MODE_RAND_BURST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/err_lfsr16.sv
// rtl/err_lfsr16.sv - 16-bit Galois LFSR with seed reload and zero-seed guard
module err_lfsr16
    import err_inj_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    // A zero state would lock the register, so a zero reload falls back to SEED
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (seed == 16'd0) ? SEED : seed;
        end else if (step) begin
            value_d = (value_q >> 1) ^ (value_q[0] ? LFSR_TAPS : 16'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/channel_err_injector.sv
// rtl/channel_err_injector.sv - XOR-mask error injector between encoder and Viterbi decoder
module channel_err_injector
    import err_inj_pkg::*;
#(
    parameter int          SYM_W = 2,
    parameter int          PER_W = 8,
    parameter int          BL_W  = 4,
    parameter int          CNT_W = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] sym_i,
    input  logic [1:0]       mode_i,
    input  logic [SYM_W-1:0] mask_i,
    input  logic [PER_W-1:0] period_i,
    input  logic [BL_W-1:0]  burst_len_i,
    input  logic [15:0]      thresh_i,
    input  logic             load_seed_i,
    input  logic [15:0]      seed_i,
    input  logic [CNT_W-1:0] max_words_i,
    output logic             valid_o,
    output logic [SYM_W-1:0] sym_o,
    output logic             err_flag_o,
    output logic [CNT_W-1:0] word_ct_o,
    output logic [CNT_W-1:0] err_word_ct_o,
    output logic [CNT_W-1:0] err_bit_ct_o
);

    localparam int CW1 = CNT_W + 1;
    localparam int BW1 = BL_W + 1;

    state_e           state_q;
    logic [PER_W-1:0] pcnt_q;
    logic [BL_W-1:0]  bcnt_q;
    logic             valid_q;
    logic [SYM_W-1:0] sym_q;
    logic             err_flag_q;
    logic [CNT_W-1:0] word_ct_q;
    logic [CNT_W-1:0] err_word_ct_q;
    logic [CNT_W-1:0] err_bit_ct_q;

    mode_e       mode;
    logic [15:0] lfsr;
    logic        rnd_hit;
    logic        pcnt_wrap;
    logic        per_hit;
    logic        trig;
    logic        in_window;
    logic        inj;
    logic        burst_last;
    logic [BL_W-1:0]  bl_eff;
    logic [CW1-1:0]   err_bit_sum;
    logic [CNT_W-1:0] err_bit_ct_d;

    assign mode      = mode_e'(mode_i);
    assign rnd_hit   = (lfsr < thresh_i);
    assign pcnt_wrap = (pcnt_q == (period_i - 1'b1));
    assign per_hit   = (period_i != '0) && pcnt_wrap;
    assign trig      = ((mode == MODE_PERIODIC) && per_hit) ||
                       ((mode == MODE_RAND_BURST) && rnd_hit);
    assign in_window = (word_ct_q < max_words_i);

    // Enable/mode drops act from the next cycle, so the current state decides injection
    assign inj = valid_i && !clear_i && in_window &&
                 ((state_q == ST_BURST) ||
                  ((state_q == ST_WAIT) && (mode == MODE_RANDOM) && rnd_hit));

    assign bl_eff     = (burst_len_i == '0) ? BL_W'(1) : burst_len_i;
    assign burst_last = (({1'b0, bcnt_q} + BW1'(1)) >= {1'b0, bl_eff});

    assign err_bit_sum  = {1'b0, err_bit_ct_q} + CW1'(popcount(32'(mask_i)));
    assign err_bit_ct_d = err_bit_sum[CNT_W] ? '1 : err_bit_sum[CNT_W-1:0];

    err_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (valid_i && !clear_i),
        .load  (load_seed_i),
        .seed  (seed_i),
        .value (lfsr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pcnt_q        <= '0;
            bcnt_q        <= '0;
            valid_q       <= 1'b0;
            sym_q         <= '0;
            err_flag_q    <= 1'b0;
            word_ct_q     <= '0;
            err_word_ct_q <= '0;
            err_bit_ct_q  <= '0;
        end else begin
            valid_q    <= valid_i;
            sym_q      <= sym_i ^ (inj ? mask_i : '0);
            err_flag_q <= inj;

            if (clear_i) begin
                state_q       <= ST_IDLE;
                pcnt_q        <= '0;
                bcnt_q        <= '0;
                word_ct_q     <= '0;
                err_word_ct_q <= '0;
                err_bit_ct_q  <= '0;
            end else begin
                if (valid_i && !(&word_ct_q)) begin
                    word_ct_q <= word_ct_q + 1'b1;
                end
                if (inj) begin
                    if (!(&err_word_ct_q)) begin
                        err_word_ct_q <= err_word_ct_q + 1'b1;
                    end
                    err_bit_ct_q <= err_bit_ct_d;
                end
                // The period counter also runs through bursts so triggers stay on a fixed grid
                if (valid_i && (state_q != ST_IDLE)) begin
                    pcnt_q <= pcnt_wrap ? '0 : pcnt_q + 1'b1;
                end

                if (!enable_i || (mode == MODE_OFF)) begin
                    state_q <= ST_IDLE;
                    bcnt_q  <= '0;
                end else begin
                    case (state_q)
                        ST_IDLE: state_q <= ST_WAIT;
                        ST_WAIT: begin
                            if (valid_i && trig) begin
                                state_q <= ST_BURST;
                                bcnt_q  <= '0;
                            end
                        end
                        ST_BURST: begin
                            if (valid_i) begin
                                if (burst_last) begin
                                    state_q <= ST_WAIT;
                                    bcnt_q  <= '0;
                                end else begin
                                    bcnt_q <= bcnt_q + 1'b1;
                                end
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign valid_o       = valid_q;
    assign sym_o         = sym_q;
    assign err_flag_o    = err_flag_q;
    assign word_ct_o     = word_ct_q;
    assign err_word_ct_o = err_word_ct_q;
    assign err_bit_ct_o  = err_bit_ct_q;

endmodule

// File: tb/tb_channel_err_injector.sv
// tb/tb_channel_err_injector.sv - scoreboard bench for channel_err_injector
module tb_channel_err_injector;

    localparam int          SYM_W = 2;
    localparam int          PER_W = 8;
    localparam int          BL_W  = 4;
    localparam int          CNT_W = 16;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          CMAX  = 65535;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable_i, clear_i, valid_i, load_seed_i;
    logic [SYM_W-1:0] sym_i, mask_i;
    logic [1:0]       mode_i;
    logic [PER_W-1:0] period_i;
    logic [BL_W-1:0]  burst_len_i;
    logic [15:0]      thresh_i, seed_i;
    logic [CNT_W-1:0] max_words_i;
    logic             valid_o, err_flag_o;
    logic [SYM_W-1:0] sym_o;
    logic [CNT_W-1:0] word_ct_o, err_word_ct_o, err_bit_ct_o;

    channel_err_injector #(
        .SYM_W(SYM_W), .PER_W(PER_W), .BL_W(BL_W), .CNT_W(CNT_W), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .clear_i(clear_i),
        .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i), .mask_i(mask_i),
        .period_i(period_i), .burst_len_i(burst_len_i), .thresh_i(thresh_i),
        .load_seed_i(load_seed_i), .seed_i(seed_i), .max_words_i(max_words_i),
        .valid_o(valid_o), .sym_o(sym_o), .err_flag_o(err_flag_o),
        .word_ct_o(word_ct_o), .err_word_ct_o(err_word_ct_o), .err_bit_ct_o(err_bit_ct_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SYM_W-1:0] sym;
        logic             flag;
        int               wc;
        int               ewc;
        int               ebc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 0;

    // Reference: "running" = injector armed, "left" = corrupted words still owed by a burst
    int m_run, m_left, m_pcnt, m_wc, m_ewc, m_ebc, m_lfsr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    function automatic int lfsr_next(input int x);
        return x[0] ? ((x >> 1) ^ 32'hB400) : (x >> 1);
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic int ones(input logic [SYM_W-1:0] m);
        int n = 0;
        for (int i = 0; i < SYM_W; i++) n += int'(m[i]);
        return n;
    endfunction

    task automatic model_reset();
        m_run = 0; m_left = 0; m_pcnt = 0; m_wc = 0; m_ewc = 0; m_ebc = 0;
        m_lfsr = int'(SEED);
    endtask

    task automatic model_cycle();
        exp_t e;
        bit   inj  = 0;
        bit   trig = 0;
        int   r    = m_lfsr;
        int   bl   = (burst_len_i == 0) ? 1 : int'(burst_len_i);
        if (clear_i) begin
            m_run = 0; m_left = 0; m_pcnt = 0; m_wc = 0; m_ewc = 0; m_ebc = 0;
        end else begin
            if (m_run != 0) begin
                if (m_left > 0) begin
                    inj = valid_i;
                    if (valid_i) m_left--;
                end else if (valid_i) begin
                    if (mode_i == 2) inj = (r < int'(thresh_i));
                    if (mode_i == 1 && period_i != 0 && m_pcnt == int'(period_i) - 1) trig = 1;
                    if (mode_i == 3 && r < int'(thresh_i)) trig = 1;
                end
                if (valid_i) m_pcnt = (m_pcnt == ((int'(period_i) + 255) % 256)) ? 0 : (m_pcnt + 1) % 256;
            end
            if (inj && m_wc >= int'(max_words_i)) inj = 0;
            if (!enable_i || mode_i == 0) begin
                m_run = 0; m_left = 0;
            end else if (m_run == 0) begin
                m_run = 1;
            end else if (trig) begin
                m_left = bl;
            end
            if (valid_i) m_wc = sat(m_wc + 1);
            if (inj) begin
                m_ewc = sat(m_ewc + 1);
                m_ebc = sat(m_ebc + ones(mask_i));
            end
        end
        if (load_seed_i) m_lfsr = (seed_i == 0) ? int'(SEED) : int'(seed_i);
        else if (valid_i && !clear_i) m_lfsr = lfsr_next(m_lfsr);
        if (valid_i) begin
            e.sym = sym_i ^ (inj ? mask_i : '0);
            e.flag = inj;
            e.wc = m_wc; e.ewc = m_ewc; e.ebc = m_ebc;
            q.push_back(e);
        end
    endtask

    task automatic cyc();
        model_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic word(input bit v, input logic [SYM_W-1:0] s);
        valid_i = v;
        sym_i   = s;
        cyc();
    endtask

    task automatic do_clear();
        clear_i = 1; valid_i = 0;
        cyc();
        clear_i = 0;
        chk("clear_word_ct", 32'(word_ct_o), 0);
        chk("clear_err_word_ct", 32'(err_word_ct_o), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_underflow actual=valid_o expected=no output");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sym_o", 32'(sym_o), 32'(e.sym));
                    chk("err_flag_o", 32'(err_flag_o), 32'(e.flag));
                    chk("word_ct_o", 32'(word_ct_o), 32'(e.wc));
                    chk("err_word_ct_o", 32'(err_word_ct_o), 32'(e.ewc));
                    chk("err_bit_ct_o", 32'(err_bit_ct_o), 32'(e.ebc));
                end
            end else begin
                chk("flag_on_invalid", 32'(err_flag_o), 0);
            end
        end
    end

    initial begin
        rst = 0; enable_i = 0; clear_i = 0; valid_i = 0; load_seed_i = 0;
        sym_i = '0; mask_i = '0; mode_i = 2'd0; period_i = '0; burst_len_i = '0;
        thresh_i = '0; seed_i = '0; max_words_i = '1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid_o", 32'(valid_o), 0);
        chk("rst_sym_o", 32'(sym_o), 0);
        chk("rst_err_flag_o", 32'(err_flag_o), 0);
        chk("rst_word_ct", 32'(word_ct_o), 0);
        chk("rst_err_word_ct", 32'(err_word_ct_o), 0);
        chk("rst_err_bit_ct", 32'(err_bit_ct_o), 0);
        rst = 1; mon_en = 1;

        // OFF: pure one-cycle pipe
        enable_i = 1; mode_i = 2'd0; mask_i = 2'b11;
        for (int i = 0; i < 300; i++) word(1, SYM_W'(i));
        chk("off_err_word_ct", 32'(err_word_ct_o), 0);
        chk("off_err_bit_ct", 32'(err_bit_ct_o), 0);
        chk("off_word_ct", 32'(word_ct_o), 300);

        // PERIODIC 32 / burst 5 / window 256
        do_clear();
        mode_i = 2'd1; period_i = 8'd32; burst_len_i = 4'd5; mask_i = 2'b01; max_words_i = 16'd256;
        word(0, '0);
        for (int i = 0; i < 300; i++) word(1, SYM_W'($urandom));
        chk("per32_err_word_ct", 32'(err_word_ct_o), 35);
        chk("per32_err_bit_ct", 32'(err_bit_ct_o), 35);

        // burst_len 0 behaves as 1
        do_clear();
        period_i = 8'd4; burst_len_i = 4'd0; mask_i = 2'b11; max_words_i = '1;
        word(0, '0);
        for (int i = 0; i < 16; i++) word(1, SYM_W'($urandom));
        chk("bl0_err_word_ct", 32'(err_word_ct_o), 3);
        chk("bl0_err_bit_ct", 32'(err_bit_ct_o), 6);

        // RANDOM against the reference LFSR
        do_clear();
        mode_i = 2'd2; thresh_i = 16'h8000; mask_i = 2'b10; load_seed_i = 1; seed_i = SEED;
        word(0, '0);
        load_seed_i = 0;
        for (int i = 0; i < 1000; i++) word(1, SYM_W'($urandom));
        chk("rand_err_word_ct", 32'(err_word_ct_o), 32'(m_ewc));
        do_clear();
        thresh_i = 16'h0000;
        word(0, '0);
        for (int i = 0; i < 200; i++) word(1, SYM_W'($urandom));
        chk("rand_t0_err_word_ct", 32'(err_word_ct_o), 0);

        // enable dropped on the third word of an 8-word burst
        do_clear();
        mode_i = 2'd1; period_i = 8'd4; burst_len_i = 4'd8; mask_i = 2'b01;
        word(0, '0);
        for (int i = 0; i < 6; i++) word(1, SYM_W'($urandom));
        enable_i = 0;
        for (int i = 0; i < 6; i++) word(1, SYM_W'($urandom));
        chk("abort_err_word_ct", 32'(err_word_ct_o), 3);
        enable_i = 1;

        // randomized: valid gaps, mode switches, seed reloads, mid-run clear
        do_clear();
        mode_i = 2'd3; thresh_i = 16'h1800; period_i = 8'(5 + $urandom_range(0, 6));
        burst_len_i = 4'($urandom_range(0, 6)); max_words_i = 16'($urandom_range(400, 1500));
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 99) == 0) mode_i = 2'($urandom_range(0, 3));
            enable_i    = ($urandom_range(0, 49) != 0);
            load_seed_i = ($urandom_range(0, 199) == 0);
            seed_i      = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            valid_i     = ($urandom_range(0, 9) < 7);
            sym_i       = SYM_W'($urandom);
            mask_i      = SYM_W'($urandom);
            if (c == 1000) begin
                clear_i = 1;
                cyc();
                clear_i = 0;
                chk("midclear_word_ct", 32'(word_ct_o), 0);
                chk("midclear_err_word_ct", 32'(err_word_ct_o), 0);
                chk("midclear_err_bit_ct", 32'(err_bit_ct_o), 0);
            end else begin
                cyc();
            end
        end

        // reset in the middle of a burst
        valid_i = 0; load_seed_i = 0; clear_i = 0;
        do_clear();
        mode_i = 2'd1; enable_i = 1; period_i = 8'd2; burst_len_i = 4'd8; mask_i = 2'b11;
        max_words_i = '1;
        word(0, '0);
        for (int i = 0; i < 4; i++) word(1, SYM_W'($urandom));
        #2;
        chk("sb_drain", 32'(q.size()), 0);
        mon_en = 0;
        rst = 0;
        #1;
        chk("midrst_err_flag_o", 32'(err_flag_o), 0);
        chk("midrst_err_word_ct", 32'(err_word_ct_o), 0);
        chk("midrst_word_ct", 32'(word_ct_o), 0);
        q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
